ocra1_grad_sequencer: RTL and testbench

Upstream feeder for the OCRA1 four-channel SPI serialiser. Accepts complete gradient update bundles (up to four 24-bit DAC words plus a channel mask) over a valid/ready handshake and buffers them in a small FIFO. It then emits them as single-cycle channel writes in the serialiser's 32-bit word format. The broadcast flag goes on the last word of each bundle, and only while the serialiser is idle, so no broadcast is ever dropped.

---
 rtl/ocra1_grad_sequencer.sv | 155 +++++++++++++++
 tb/tb_ocra1_grad_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocra1_grad_sequencer.sv
// Buffers gradient update bundles and replays them as single-cycle channel writes
// for the OCRA1 serialiser; the final word of each bundle carries the broadcast flag.
module ocra1_grad_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        upd_valid_i,
  output logic                        upd_ready_o,
  input  logic [3:0]                  upd_mask_i,
  input  logic [23:0]                 upd_x_i,
  input  logic [23:0]                 upd_y_i,
  input  logic [23:0]                 upd_z_i,
  input  logic [23:0]                 upd_z2_i,
  output logic [31:0]                 iface_data_o,
  output logic                        iface_valid_o,
  input  logic                        iface_busy_i,
  input  logic                        iface_data_lost_i,
  input  logic                        clr_status_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [15:0]                 updates_sent_o,
  output logic                        lost_sticky_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GUARD_CYCLES + 2);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_e;

  state_e        state_q, state_d;
  logic [3:0]    mask_mem [FIFO_DEPTH];
  logic [95:0]   word_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;
  logic [3:0]    wmask_q, wmask_d;
  logic [95:0]   wwords_q;
  logic [GW-1:0] guard_q, guard_d;
  logic [31:0]   data_q;
  logic [15:0]   sent_q;
  logic          lost_q;
  logic          push, pop, emit, bcast;
  logic [1:0]    ch;
  logic [31:0]   emit_word;

  function automatic logic multi_bit(input logic [3:0] m);
    return (m & (m - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd3;
    if (m[2]) r = 2'd2;
    if (m[1]) r = 2'd1;
    if (m[0]) r = 2'd0;
    return r;
  endfunction

  function automatic logic [23:0] word_sel(input logic [95:0] w, input logic [1:0] c);
    logic [23:0] r;
    case (c)
      2'd0:    r = w[23:0];
      2'd1:    r = w[47:24];
      2'd2:    r = w[71:48];
      default: r = w[95:72];
    endcase
    return r;
  endfunction

  assign push = upd_valid_i && ready_q;

  always_comb begin
    state_d = state_q;
    wmask_d = wmask_q;
    guard_d = guard_q;
    pop     = 1'b0;
    emit    = 1'b0;
    bcast   = 1'b0;
    ch      = lowest_ch(wmask_q);
    if (guard_q != '0) guard_d = guard_q - GW'(1);
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          wmask_d = mask_mem[rd_ptr_q];
          if (multi_bit(wmask_d))  state_d = S_WRITE;
          else if (wmask_d != '0)  state_d = S_HOLD;
        end
      end
      S_WRITE: begin
        emit    = 1'b1;
        wmask_d = wmask_q & (wmask_q - 4'd1);
        if (!multi_bit(wmask_d)) state_d = S_HOLD;
      end
      S_HOLD: begin
        // Busy is not trusted until the guard window after the previous broadcast expires.
        if (!iface_busy_i && guard_q == '0) begin
          emit    = 1'b1;
          bcast   = 1'b1;
          guard_d = GW'(GUARD_CYCLES);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign level_d   = level_q + LW'(push) - LW'(pop);
  assign emit_word = {5'd0, ch, bcast, word_sel(wwords_q, ch)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      wmask_q  <= '0;
      guard_q  <= '0;
      data_q   <= '0;
      sent_q   <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ready_q <= (level_d < LW'(FIFO_DEPTH));
      wmask_q <= wmask_d;
      guard_q <= guard_d;
      if (emit) data_q <= emit_word;
      if (clr_status_i)       sent_q <= '0;
      else if (emit && bcast) sent_q <= sent_q + 16'd1;
      if (iface_data_lost_i)  lost_q <= 1'b1;
      else if (clr_status_i)  lost_q <= 1'b0;
    end
  end

  // Bundle storage and working words are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wr_ptr_q] <= upd_mask_i;
      word_mem[wr_ptr_q] <= {upd_z2_i, upd_z_i, upd_y_i, upd_x_i};
    end
    if (pop) wwords_q <= word_mem[rd_ptr_q];
  end

  assign upd_ready_o    = ready_q;
  assign iface_valid_o  = emit;
  assign iface_data_o   = emit ? emit_word : data_q;
  assign fifo_level_o   = level_q;
  assign updates_sent_o = sent_q;
  assign lost_sticky_o  = lost_q;
endmodule

// File: tb/tb_ocra1_grad_sequencer.sv
// Self-checking bench for ocra1_grad_sequencer: scenario tasks compare observed channel
// writes against a bundle-level reference model of the expected word stream.
module tb_ocra1_grad_sequencer;
  localparam int DEPTH = 4;
  localparam int GUARD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid_i = 1'b0;
  logic        upd_ready_o;
  logic [3:0]  upd_mask_i = '0;
  logic [23:0] upd_x_i = '0, upd_y_i = '0, upd_z_i = '0, upd_z2_i = '0;
  logic [31:0] iface_data_o;
  logic        iface_valid_o;
  logic        iface_busy_i = 1'b0;
  logic        iface_data_lost_i = 1'b0;
  logic        clr_status_i = 1'b0;
  logic [2:0]  fifo_level_o;
  logic [15:0] updates_sent_o;
  logic        lost_sticky_o;

  ocra1_grad_sequencer #(.FIFO_DEPTH(DEPTH), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_mask_i(upd_mask_i),
    .upd_x_i(upd_x_i), .upd_y_i(upd_y_i), .upd_z_i(upd_z_i), .upd_z2_i(upd_z2_i),
    .iface_data_o(iface_data_o), .iface_valid_o(iface_valid_o), .iface_busy_i(iface_busy_i),
    .iface_data_lost_i(iface_data_lost_i), .clr_status_i(clr_status_i),
    .fifo_level_o(fifo_level_o), .updates_sent_o(updates_sent_o), .lost_sticky_o(lost_sticky_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] obs_q[$];
  int          obs_t[$];
  logic        obs_b[$];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic busy_rand = 1'b0;

  always @(negedge clk) begin
    if (!rst && iface_valid_o) begin
      obs_q.push_back(iface_data_o);
      obs_t.push_back(cyc);
      obs_b.push_back(iface_busy_i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy_rand) iface_busy_i = ($urandom_range(0, 2) == 0);
  endtask

  task automatic clear_q();
    obs_q.delete(); obs_t.delete(); obs_b.delete(); exp_q.delete();
  endtask

  // Reference model: enabled channels in ascending order, broadcast on the highest one.
  task automatic expect_bundle(input logic [3:0] m, input logic [23:0] w0, w1, w2, w3);
    logic [23:0] w[4];
    int hi;
    w  = '{w0, w1, w2, w3};
    hi = -1;
    for (int i = 0; i < 4; i++) if (m[i]) hi = i;
    for (int i = 0; i < 4; i++)
      if (m[i]) exp_q.push_back({5'd0, 2'(i), (i == hi), w[i]});
  endtask

  task automatic push(input logic [3:0] m, input logic [23:0] x, y, z, z2, output int c);
    int n;
    n = 0;
    upd_valid_i = 1'b1; upd_mask_i = m;
    upd_x_i = x; upd_y_i = y; upd_z_i = z; upd_z2_i = z2;
    while (!upd_ready_o && n < 300) begin tick(); n++; end
    c = cyc;
    if (!upd_ready_o) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: ready=%0b after %0d cycles, required 1", upd_ready_o, n);
    end else begin
      expect_bundle(m, x, y, z, z2);
    end
    tick();
    upd_valid_i = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int bound);
    for (int i = 0; i < bound && obs_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (upd_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b, expected 0", upd_ready_o); end
    n_checks++; if (iface_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b, expected 0", iface_valid_o); end
    n_checks++; if (iface_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h, expected 0", iface_data_o); end
    n_checks++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d, expected 0", fifo_level_o); end
    n_checks++; if (updates_sent_o !== 16'd0) begin n_fail++; $display("FAIL rst_sent: got %0d, expected 0", updates_sent_o); end
    n_checks++; if (lost_sticky_o !== 1'b0) begin n_fail++; $display("FAIL rst_sticky: got %0b, expected 0", lost_sticky_o); end
    rst = 1'b0;
    tick();
    n_checks++; if (upd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %0b, expected 1", upd_ready_o); end
  endtask

  task automatic test_timing_all4();
    int c;
    clear_q();
    push(4'hF, 24'h000001, 24'h000002, 24'h000003, 24'h000004, c);
    wait_obs(4, 20);
    repeat (3) tick();
    exp_q = '{32'h00000001, 32'h02000002, 32'h04000003, 32'h07000004};
    n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL all4_count: got %0d, expected 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_t[i] !== c + 2 + i) begin
        n_fail++;
        $display("FAIL all4_word[%0d]: got %h at cycle %0d, expected %h at cycle %0d", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hx, (i < obs_t.size()) ? obs_t[i] : -1, exp_q[i], c + 2 + i);
      end
    end
    n_checks++; if (iface_valid_o !== 1'b0 || iface_data_o !== 32'h07000004) begin n_fail++; $display("FAIL all4_hold: got valid=%0b data=%h, expected 0/07000004", iface_valid_o, iface_data_o); end
    n_checks++; if (updates_sent_o !== 16'd1) begin n_fail++; $display("FAIL all4_sent: got %0d, expected 1", updates_sent_o); end
  endtask

  task automatic test_sparse();
    int c;
    clear_q();
    push(4'h5, 24'hABCDEF, 24'h111111, 24'h123456, 24'h222222, c);
    wait_obs(2, 20);
    repeat (6) tick();
    exp_q = '{32'h00ABCDEF, 32'h05123456};
    n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL sparse_count: got %0d, expected 2", obs_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL sparse_word[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_spacing();
    int c;
    clear_q();
    push(4'h1, 24'h0000A1, 24'h0, 24'h0, 24'h0, c);
    push(4'h1, 24'h0000B2, 24'h0, 24'h0, 24'h0, c);
    wait_obs(1, 20);
    iface_busy_i = 1'b1;
    repeat (20) tick();
    iface_busy_i = 1'b0;
    wait_obs(2, 40);
    repeat (3) tick();
    n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL busy_count: got %0d, expected 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL busy_word[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
    if (obs_q.size() >= 2) begin
      n_checks++;
      if (obs_t[1] - obs_t[0] !== 21 || obs_b[1] !== 1'b0) begin
        n_fail++; $display("FAIL busy_gap: got gap %0d busy=%0b, expected gap 21 busy=0", obs_t[1] - obs_t[0], obs_b[1]);
      end
    end
  endtask

  task automatic test_full();
    int c;
    clear_q();
    iface_busy_i = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++)
      push(4'($urandom_range(1, 15)), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), c);
    n_checks++; if (fifo_level_o !== 3'd4 || upd_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_state: got level=%0d ready=%0b, expected 4/0", fifo_level_o, upd_ready_o); end
    upd_valid_i = 1'b1; upd_mask_i = 4'hF; upd_x_i = 24'hDEAD00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (fifo_level_o !== 3'd4 || upd_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL full_hold[%0d]: got level=%0d ready=%0b, expected 4/0", i, fifo_level_o, upd_ready_o);
      end
    end
    upd_valid_i = 1'b0;
    iface_busy_i = 1'b0;
    wait_obs(exp_q.size(), 200);
    repeat (8) tick();
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL full_word[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
    n_checks++; if (fifo_level_o !== 3'd0 || upd_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_drain: got level=%0d ready=%0b, expected 0/1", fifo_level_o, upd_ready_o); end
  endtask

  task automatic test_mask0();
    int c;
    clear_q();
    clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
    push(4'h8, 24'h0, 24'h0, 24'h0, 24'h5A5A5A, c);
    push(4'h0, 24'h111111, 24'h222222, 24'h333333, 24'h444444, c);
    push(4'h8, 24'h0, 24'h0, 24'h0, 24'hA5A5A5, c);
    wait_obs(2, 40);
    repeat (10) tick();
    n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL mask0_count: got %0d, expected 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mask0_word[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
    n_checks++; if (updates_sent_o !== 16'd2) begin n_fail++; $display("FAIL mask0_sent: got %0d, expected 2", updates_sent_o); end
  endtask

  task automatic test_status();
    iface_data_lost_i = 1'b1; clr_status_i = 1'b1; tick();
    iface_data_lost_i = 1'b0; clr_status_i = 1'b0;
    n_checks++; if (lost_sticky_o !== 1'b1) begin n_fail++; $display("FAIL stat_setwins: got %0b, expected 1", lost_sticky_o); end
    tick();
    n_checks++; if (lost_sticky_o !== 1'b1) begin n_fail++; $display("FAIL stat_sticky: got %0b, expected 1", lost_sticky_o); end
    clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
    n_checks++; if (lost_sticky_o !== 1'b0 || updates_sent_o !== 16'd0) begin n_fail++; $display("FAIL stat_clear: got sticky=%0b sent=%0d, expected 0/0", lost_sticky_o, updates_sent_o); end
  endtask

  task automatic test_random();
    int c, nz, prev;
    clear_q();
    clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
    nz = 0;
    busy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(0, 15));
      if (m != 4'h0) nz++;
      push(m, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), c);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_obs(exp_q.size(), 3000);
    busy_rand = 1'b0;
    tick();
    iface_busy_i = 1'b0;
    repeat (10) tick();
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_word[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
    prev = -1000;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i][24]) begin
        n_checks++;
        if (obs_b[i] !== 1'b0 || obs_t[i] - prev < GUARD + 1) begin
          n_fail++; $display("FAIL rand_bcast[%0d]: got busy=%0b gap=%0d, expected busy=0 gap>=%0d", i, obs_b[i], obs_t[i] - prev, GUARD + 1);
        end
        prev = obs_t[i];
      end
    end
    n_checks++; if (updates_sent_o !== 16'(nz)) begin n_fail++; $display("FAIL rand_sent: got %0d, expected %0d", updates_sent_o, nz); end
  endtask

  task automatic test_reset_mid();
    int c;
    clear_q();
    iface_data_lost_i = 1'b1; tick(); iface_data_lost_i = 1'b0;
    push(4'hF, 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D, c);
    push(4'h3, 24'h010101, 24'h020202, 24'h0, 24'h0, c);
    wait_obs(1, 20);
    n_checks++; if (fifo_level_o !== 3'd1 || iface_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got level=%0d valid=%0b, expected 1/1", fifo_level_o, iface_valid_o); end
    rst = 1'b1;
    #1;
    clear_q();
    n_checks++; if (iface_valid_o !== 1'b0 || iface_data_o !== 32'h0) begin n_fail++; $display("FAIL mid_out: got valid=%0b data=%h, expected 0/0", iface_valid_o, iface_data_o); end
    n_checks++; if (fifo_level_o !== 3'd0 || upd_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_fifo: got level=%0d ready=%0b, expected 0/0", fifo_level_o, upd_ready_o); end
    n_checks++; if (updates_sent_o !== 16'd0 || lost_sticky_o !== 1'b0) begin n_fail++; $display("FAIL mid_stat: got sent=%0d sticky=%0b, expected 0/0", updates_sent_o, lost_sticky_o); end
    tick();
    rst = 1'b0;
    repeat (12) tick();
    n_checks++; if (obs_q.size() !== 0 || fifo_level_o !== 3'd0 || upd_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_after: got writes=%0d level=%0d ready=%0b, expected 0/0/1", obs_q.size(), fifo_level_o, upd_ready_o); end
  endtask

  initial begin
    test_reset();
    test_timing_all4();
    test_sparse();
    test_busy_spacing();
    test_full();
    test_mask0();
    test_status();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
